mdio_master_c45: RTL and testbench
==================================

MDIO_MASTER_C45 -- requirements
Module: mdio_master_c45

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 25, meaning clk cycles per MDC half-period (legal range 2..255).
REQ-002 The block SHALL have parameter PRE_LEN, default 32, meaning preamble bit count (legal range 0..32; 0 = preamble suppression).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, the single clock for all logic.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port mdio_mdc, output, 1 bit: generated MDC.
REQ-006 The block SHALL have port mdio_t, output, 1 bit: tri-state control (1 = released/input, 0 = driven).
REQ-007 The block SHALL have port mdio_o, output, 1 bit: MDIO output data.
REQ-008 The block SHALL have port mdio_i, input, 1 bit: MDIO input data.
REQ-009 The block SHALL have port start, input, 1 bit: single-cycle request pulse.
REQ-010 The block SHALL have port c45, input, 2 bits: 0 = Clause 22 frame, 1 = Clause 45 frame.
REQ-011 The block SHALL have port op, input, 2 bits: frame opcode.
REQ-012 The block SHALL have port prtad, input, 5 bits: PHY/port address.
REQ-013 The block SHALL have port devad, input, 5 bits: register address (Clause 22) or device address (Clause 45).
REQ-014 The block SHALL have port wr_data, input, 16 bits: write data, or address value for a Clause 45 address frame.
REQ-015 The block SHALL have ports busy, done, rd_valid and rd_err, each output, 1 bit.
REQ-016 The block SHALL have port rd_data, output, 16 bits: captured read data.

Function
REQ-017 start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored, with no effect on the current frame.
REQ-018 On acceptance, c45, op, prtad, devad and wr_data SHALL be latched, and busy SHALL be 1 from the next cycle.
REQ-019 The frame SHALL be PRE_LEN ones, then ST(2), OP(2), PRTAD(5), DEVAD(5), TA(2), DATA(16), sent MSB first.
REQ-020 ST SHALL be 01 for Clause 22 and 00 for Clause 45; op SHALL be transmitted verbatim.
REQ-021 A frame SHALL be a read when (c45=0 and op=10), or (c45=1 and op[1]=1); all other frames SHALL be writes.
REQ-022 For writes, TA SHALL be driven as 10 and DATA as wr_data.
REQ-023 For reads, mdio_t SHALL be 1 from the first TA bit through the last DATA bit.
REQ-024 Each bit period SHALL be 2*CLK_DIV clk cycles, with mdio_mdc low for the first CLK_DIV cycles and high for the second CLK_DIV cycles.
REQ-025 mdio_o and mdio_t SHALL update only at bit-period start, i.e. on an MDC falling edge.
REQ-026 mdio_i SHALL be sampled in the clk cycle where mdio_mdc rises.
REQ-027 The state machine SHALL use states IDLE -> PREAMBLE (skipped if PRE_LEN=0) -> FRAME (32 bits, counter 31..0) -> DONE -> IDLE.
REQ-028 The state machine SHALL spend exactly one clk cycle in DONE.
REQ-029 The total busy time SHALL be (PRE_LEN+32)*2*CLK_DIV + 1 cycles.
REQ-030 done SHALL pulse 1 for one cycle in DONE, and busy SHALL fall in the same cycle.
REQ-031 For reads, the 16 DATA samples SHALL shift into rd_data MSB first.
REQ-032 For reads, rd_valid SHALL pulse with done, and rd_data SHALL hold until the next read completes.
REQ-033 For reads, if the second TA bit samples 1 (no PHY response), rd_err SHALL pulse with done and rd_valid SHALL stay 0.
REQ-034 For writes, rd_valid=0, rd_err=0 and rd_data SHALL be unchanged.
REQ-035 In IDLE, mdio_mdc SHALL be 0, mdio_t=1 and mdio_o=1.
REQ-036 A start arriving in the DONE cycle SHALL be ignored; a start in the cycle after DONE SHALL be accepted.
REQ-037 The MDC divider counter SHALL be CLK_DIV-width safe, and the bit counter SHALL wrap only via state change, never by arithmetic overflow.

Reset
REQ-038 With rst_n=0 at a clk edge, the block SHALL enter IDLE with mdio_mdc=0, mdio_t=1, mdio_o=1, busy=0, done=0, rd_valid=0, rd_err=0 and rd_data=0.
REQ-039 Reset mid-frame SHALL abort the frame immediately, release the bus the next cycle, and produce no done pulse.

Verification (CLK_DIV=2, PRE_LEN=32 unless stated)
REQ-040 C22 write, prtad=01, devad=00, wr_data=1140 -> MDIO bit sequence 32x1, 01 01 00001 00000 10 0001000101000000; busy for 257 cycles; done pulse; rd_valid=0.
REQ-041 C45 read, op=11, PHY returning 0 then 0xA5C3 -> rd_data=A5C3, rd_valid=1 and rd_err=0 with done; mdio_t=1 for 18 bit periods.
REQ-042 C45 read with mdio_i held at 1 -> rd_err=1, rd_valid=0, rd_data unchanged.
REQ-043 PRE_LEN=0, C45 address frame, wr_data=0x0005 -> first MDC bit is ST=00; busy 129 cycles.
REQ-044 start pulsed again mid-frame and in the DONE cycle -> both ignored; a start one cycle after DONE -> accepted.
REQ-045 rst_n=0 for one cycle during a DATA bit -> next cycle mdio_t=1, busy=0, no done pulse; a new start then produces a complete, correct frame.

Source files
------------

// File: rtl/mdio_master_c45.sv
// -----------------------------------------------------------------------------
// mdio_master_c45
// MDIO management master for Clause 22 and Clause 45 frames. Generates MDC from
// clk, serialises preamble + ST/OP/PRTAD/DEVAD/TA/DATA MSB first, releases the
// bus for the turnaround and data of read frames, and captures read data.
//
// Ports
//   clk       system clock (all logic)
//   rst_n     synchronous active-low reset
//   mdio_mdc  generated MDC (low first half, high second half of each bit)
//   mdio_t    MDIO tri-state control, 1 = released, 0 = driven
//   mdio_o    MDIO output data
//   mdio_i    MDIO input data, sampled in the clk cycle where MDC rises
//   start     request pulse, accepted only while busy = 0
//   c45       0 = Clause 22 frame, non-zero = Clause 45 frame
//   op        opcode, sent verbatim
//   prtad     PHY/port address
//   devad     register address (C22) or device address (C45)
//   wr_data   write data or C45 address value
//   busy      frame in progress (covers the DONE cycle)
//   done      one-cycle completion pulse
//   rd_valid  pulses with done when a read returned data
//   rd_err    pulses with done when a read saw no PHY turnaround
//   rd_data   last successfully read data
// -----------------------------------------------------------------------------
module mdio_master_c45 #(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mdio_mdc,
  output logic        mdio_t,
  output logic        mdio_o,
  input  logic        mdio_i,
  input  logic        start,
  input  logic [1:0]  c45,
  input  logic [1:0]  op,
  input  logic [4:0]  prtad,
  input  logic [4:0]  devad,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        rd_valid,
  output logic        rd_err,
  output logic [15:0] rd_data
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]       PRE_LAST = 6'((PRE_LEN > 0) ? (PRE_LEN - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_FRAME = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [5:0]         r_cnt;
  logic [31:0]        r_frame;
  logic               r_is_rd;
  logic [15:0]        r_shift;
  logic               r_ta_err;
  logic               r_mdc, r_t, r_o, r_busy, r_done, r_rd_valid, r_rd_err;
  logic [15:0]        r_rd_data;

  state_t             w_state_nxt;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [5:0]         w_cnt_nxt;
  logic [31:0]        w_frame_nxt;
  logic               w_is_rd_nxt;
  logic               w_accept, w_bit_end, w_rd_req, w_sample;
  logic [1:0]         w_st;
  logic               w_mdc_nxt, w_t_nxt, w_o_nxt;

  assign w_accept  = start & (r_state == S_IDLE);
  assign w_bit_end = (r_div == DIV_LAST);
  // MDC rises in the cycle where the divider first reaches the half point
  assign w_sample  = (r_state == S_FRAME) & (r_div == DIV_HALF);

  // Frame word and read/write classification for a newly accepted request
  always_comb begin
    w_st     = (c45 != 2'b00) ? 2'b00 : 2'b01;
    w_rd_req = (c45 == 2'b00) ? (op == 2'b10) : op[1];
    if (w_accept) begin
      w_frame_nxt = {w_st, op, prtad, devad, 2'b10, wr_data};
      w_is_rd_nxt = w_rd_req;
    end else begin
      w_frame_nxt = r_frame;
      w_is_rd_nxt = r_is_rd;
    end
  end

  // Next-state, divider and bit-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = DIV_ZERO;
        if (start) begin
          if (PRE_LEN > 0) begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = PRE_LAST;
          end else begin
            w_state_nxt = S_FRAME;
            w_cnt_nxt   = 6'd31;
          end
        end else begin
          w_cnt_nxt = 6'd0;
        end
      end
      S_PRE, S_FRAME: begin
        if (w_bit_end) begin
          w_div_nxt = DIV_ZERO;
          // bit counter never wraps: the last bit of a phase changes state
          if (r_cnt != 6'd0) begin
            w_cnt_nxt = r_cnt - 6'd1;
          end else if (r_state == S_PRE) begin
            w_state_nxt = S_FRAME;
            w_cnt_nxt   = 6'd31;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered bus outputs; data only changes with the
  // bit counter, i.e. at a bit-period start where MDC falls
  always_comb begin
    w_mdc_nxt = 1'b0;
    w_t_nxt   = 1'b1;
    w_o_nxt   = 1'b1;
    case (w_state_nxt)
      S_PRE: begin
        w_mdc_nxt = (w_div_nxt >= DIV_HALF);
        w_t_nxt   = 1'b0;
        w_o_nxt   = 1'b1;
      end
      S_FRAME: begin
        w_mdc_nxt = (w_div_nxt >= DIV_HALF);
        // reads release the bus for TA (bits 17,16) and DATA (15..0)
        if (w_is_rd_nxt && (w_cnt_nxt <= 6'd17)) begin
          w_t_nxt = 1'b1;
          w_o_nxt = 1'b1;
        end else begin
          w_t_nxt = 1'b0;
          w_o_nxt = w_frame_nxt[w_cnt_nxt[4:0]];
        end
      end
      default: begin
        w_mdc_nxt = 1'b0;
        w_t_nxt   = 1'b1;
        w_o_nxt   = 1'b1;
      end
    endcase
  end

  // State, counters, latched request and registered bus/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= DIV_ZERO;
      r_cnt   <= 6'd0;
      r_frame <= 32'h0000_0000;
      r_is_rd <= 1'b0;
      r_mdc   <= 1'b0;
      r_t     <= 1'b1;
      r_o     <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_frame <= w_frame_nxt;
      r_is_rd <= w_is_rd_nxt;
      r_mdc   <= w_mdc_nxt;
      r_t     <= w_t_nxt;
      r_o     <= w_o_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Read capture: second TA bit flags a missing PHY, DATA shifts in MSB first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= 16'h0000;
      r_ta_err   <= 1'b0;
      r_rd_data  <= 16'h0000;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      if (w_sample && r_is_rd) begin
        if (r_cnt == 6'd16) begin
          r_ta_err <= mdio_i;
        end else if (r_cnt < 6'd16) begin
          r_shift <= {r_shift[14:0], mdio_i};
        end else begin
          r_ta_err <= r_ta_err;
        end
      end
      if ((r_state == S_FRAME) && (w_state_nxt == S_DONE) && r_is_rd) begin
        if (r_ta_err) begin
          r_rd_err <= 1'b1;
        end else begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= r_shift;
        end
      end
    end
  end

  assign mdio_mdc = r_mdc;
  assign mdio_t   = r_t;
  assign mdio_o   = r_o;
  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_mdio_master_c45.sv
// -----------------------------------------------------------------------------
// tb_mdio_master_c45
// Two instances: index 0 with CLK_DIV=2, PRE_LEN=32 and index 1 with
// CLK_DIV=2, PRE_LEN=0. A negedge monitor records the MDIO bit stream at each
// MDC rise, counts status pulses and plays a PHY on mdio_i. Frames are checked
// against a bit-list model built from the frame format rules.
// -----------------------------------------------------------------------------
module tb_mdio_master_c45;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_v;
  logic [1:0]  c45_v   [2];
  logic [1:0]  op_v    [2];
  logic [4:0]  prtad_v [2];
  logic [4:0]  devad_v [2];
  logic [15:0] wd_v    [2];
  logic [1:0]  mdio_i_v;
  wire  [1:0]  mdc_w, t_w, o_w, busy_w, done_w, valid_w, err_w;
  wire  [15:0] rd_data0, rd_data1;

  int          n_tests = 0;
  int          n_fail  = 0;

  // monitor state (written only by the monitor process)
  int          mon_n    [2] = '{0, 0};
  logic [63:0] mon_o    [2] = '{64'h0, 64'h0};
  logic [63:0] mon_t    [2] = '{64'h0, 64'h0};
  int          mon_busy [2] = '{0, 0};
  int          mon_done [2] = '{0, 0};
  int          mon_val  [2] = '{0, 0};
  int          mon_err  [2] = '{0, 0};
  int          mon_mis  [2] = '{0, 0};
  int          mon_hi   [2] = '{0, 0};
  int          mon_bad  [2] = '{0, 0};
  logic [1:0]  prev_mdc = 2'b00, prev_o = 2'b11, prev_t = 2'b11, prev_busy = 2'b00;

  // PHY behaviour and model state (written only by the stimulus process)
  logic [1:0]  phy_mode = 2'b00;
  logic [15:0] phy_data [2] = '{16'h0, 16'h0};
  logic [15:0] exp_rd   [2] = '{16'h0, 16'h0};

  always #5 clk = ~clk;

  mdio_master_c45 #(.CLK_DIV(2), .PRE_LEN(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mdio_mdc(mdc_w[0]), .mdio_t(t_w[0]), .mdio_o(o_w[0]),
    .mdio_i(mdio_i_v[0]), .start(start_v[0]), .c45(c45_v[0]), .op(op_v[0]),
    .prtad(prtad_v[0]), .devad(devad_v[0]), .wr_data(wd_v[0]), .busy(busy_w[0]),
    .done(done_w[0]), .rd_valid(valid_w[0]), .rd_err(err_w[0]), .rd_data(rd_data0));

  mdio_master_c45 #(.CLK_DIV(2), .PRE_LEN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mdio_mdc(mdc_w[1]), .mdio_t(t_w[1]), .mdio_o(o_w[1]),
    .mdio_i(mdio_i_v[1]), .start(start_v[1]), .c45(c45_v[1]), .op(op_v[1]),
    .prtad(prtad_v[1]), .devad(devad_v[1]), .wr_data(wd_v[1]), .busy(busy_w[1]),
    .done(done_w[1]), .rd_valid(valid_w[1]), .rd_err(err_w[1]), .rd_data(rd_data1));

  function automatic int pl_of(input int g);
    return (g == 0) ? 32 : 0;
  endfunction

  function automatic logic [15:0] rd_of(input int g);
    return (g == 0) ? rd_data0 : rd_data1;
  endfunction

  // PHY answer for frame bit k: TA1 released, TA2 driven 0, then data MSB first
  function automatic logic phy_bit(input int g, input int k);
    int f;
    f = k - pl_of(g);
    if (phy_mode[g]) return 1'b1;
    if (f == 15) return 1'b0;
    if (f >= 16 && f <= 31) return phy_data[g][31 - f];
    return 1'b1;
  endfunction

  function automatic logic is_read(input logic [1:0] c, input logic [1:0] op);
    return (c == 2'd0) ? (op == 2'b10) : op[1];
  endfunction

  // Expected bus stream: per bit, o (1 where released) and t
  function automatic void model(input int pl, input logic [1:0] c, input logic [1:0] op,
                                input logic [4:0] pa, input logic [4:0] da,
                                input logic [15:0] wd,
                                output logic [63:0] eo, output logic [63:0] et);
    bit qo[$];
    bit qt[$];
    logic [13:0] hdr;
    hdr = {(c == 2'd0) ? 2'b01 : 2'b00, op, pa, da};
    for (int i = 0; i < pl; i++) begin qo.push_back(1'b1); qt.push_back(1'b0); end
    for (int i = 13; i >= 0; i--) begin qo.push_back(hdr[i]); qt.push_back(1'b0); end
    if (is_read(c, op)) begin
      for (int i = 0; i < 18; i++) begin qo.push_back(1'b1); qt.push_back(1'b1); end
    end else begin
      qo.push_back(1'b1); qt.push_back(1'b0);
      qo.push_back(1'b0); qt.push_back(1'b0);
      for (int i = 15; i >= 0; i--) begin qo.push_back(wd[i]); qt.push_back(1'b0); end
    end
    eo = 64'h0;
    et = 64'h0;
    foreach (qo[i]) begin
      eo = {eo[62:0], qo[i]};
      et = {et[62:0], qt[i]};
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor + PHY: acceptance follows the rule "start counts only while busy=0"
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        mdio_i_v[g] <= 1'b1;
      end else if (start_v[g] && !busy_w[g]) begin
        mon_n[g] <= 0; mon_o[g] <= 64'h0; mon_t[g] <= 64'h0;
        mon_busy[g] <= 0; mon_done[g] <= 0; mon_val[g] <= 0; mon_err[g] <= 0;
        mon_mis[g] <= 0; mon_hi[g] <= 0; mon_bad[g] <= 0;
        mdio_i_v[g] <= phy_bit(g, 0);
      end else begin
        if (busy_w[g]) mon_busy[g] <= mon_busy[g] + 1;
        if (done_w[g]) mon_done[g] <= mon_done[g] + 1;
        if (valid_w[g]) mon_val[g] <= mon_val[g] + 1;
        if (err_w[g]) mon_err[g] <= mon_err[g] + 1;
        if ((valid_w[g] || err_w[g]) && !done_w[g]) mon_mis[g] <= mon_mis[g] + 1;
        if (mdc_w[g]) mon_hi[g] <= mon_hi[g] + 1;
        if (mdc_w[g] && !prev_mdc[g]) begin
          mon_o[g] <= {mon_o[g][62:0], o_w[g] | t_w[g]};
          mon_t[g] <= {mon_t[g][62:0], t_w[g]};
          mon_n[g] <= mon_n[g] + 1;
        end
        if (!mdc_w[g] && prev_mdc[g]) mdio_i_v[g] <= phy_bit(g, mon_n[g]);
        if (busy_w[g] && prev_busy[g] && ((o_w[g] != prev_o[g]) || (t_w[g] != prev_t[g]))
            && !(!mdc_w[g] && prev_mdc[g]))
          mon_bad[g] <= mon_bad[g] + 1;
      end
      prev_mdc[g]  <= mdc_w[g];
      prev_o[g]    <= o_w[g];
      prev_t[g]    <= t_w[g];
      prev_busy[g] <= busy_w[g];
    end
  end

  task automatic set_req(input int g, input logic [1:0] c, input logic [1:0] op,
                         input logic [4:0] pa, input logic [4:0] da, input logic [15:0] wd);
    c45_v[g] = c; op_v[g] = op; prtad_v[g] = pa; devad_v[g] = da; wd_v[g] = wd;
  endtask

  task automatic start_frame(input int g, input logic [1:0] c, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] da, input logic [15:0] wd);
    @(posedge clk); #1;
    set_req(g, c, op, pa, da, wd);
    start_v[g] = 1'b1;
    @(posedge clk); #1;
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while (mon_done[g] == 0 && n < 4000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_bits(input int g, input logic [1:0] c, input logic [1:0] op,
                            input logic [4:0] pa, input logic [4:0] da, input logic [15:0] wd);
    logic [63:0] eo, et;
    model(pl_of(g), c, op, pa, da, wd, eo, et);
    chk("nbits", 64'(mon_n[g]), 64'(pl_of(g) + 32));
    chk("bits_o", mon_o[g], eo);
    chk("bits_t", mon_t[g], et);
  endtask

  task automatic check_frame(input int g, input logic [1:0] c, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] da, input logic [15:0] wd);
    int  n;
    logic ev, ee;
    n = pl_of(g) + 32;
    check_bits(g, c, op, pa, da, wd);
    chk("busy_cycles", 64'(mon_busy[g]), 64'(n * 4 + 1));
    chk("done_pulses", 64'(mon_done[g]), 64'd1);
    chk("mdc_high_cycles", 64'(mon_hi[g]), 64'(n * 2));
    chk("io_change_off_fall", 64'(mon_bad[g]), 64'd0);
    chk("status_without_done", 64'(mon_mis[g]), 64'd0);
    ev = 1'b0;
    ee = 1'b0;
    if (is_read(c, op)) begin
      ee = phy_mode[g];
      ev = !phy_mode[g];
      if (ev) exp_rd[g] = phy_data[g];
    end
    chk("rd_valid", 64'(mon_val[g]), 64'(ev));
    chk("rd_err", 64'(mon_err[g]), 64'(ee));
    chk("rd_data", 64'(rd_of(g)), 64'(exp_rd[g]));
  endtask

  task automatic run(input int g, input logic [1:0] c, input logic [1:0] op,
                     input logic [4:0] pa, input logic [4:0] da, input logic [15:0] wd,
                     input logic mode, input logic [15:0] pdata);
    phy_mode[g] = mode;
    phy_data[g] = pdata;
    start_frame(g, c, op, pa, da, wd);
    wait_done(g);
    check_frame(g, c, op, pa, da, wd);
  endtask

  initial begin
    logic [22:0] rst_exp;
    int          g, n;
    logic [1:0]  c, op;
    logic [4:0]  pa, da;
    logic [15:0] wd;

    rst_n = 1'b0;
    start_v = 2'b00;
    for (int i = 0; i < 2; i++) set_req(i, 2'd0, 2'b00, 5'd0, 5'd0, 16'h0);
    rst_exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state0", 64'({mdc_w[0], t_w[0], o_w[0], busy_w[0], done_w[0], valid_w[0], err_w[0], rd_data0}), 64'(rst_exp));
    chk("reset_state1", 64'({mdc_w[1], t_w[1], o_w[1], busy_w[1], done_w[1], valid_w[1], err_w[1], rd_data1}), 64'(rst_exp));
    rst_n = 1'b1;

    // C22 write of the spec example
    run(0, 2'd0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0);
    // C45 read with PHY data, then with no PHY response
    run(0, 2'd1, 2'b11, 5'h05, 5'h03, 16'h0, 1'b0, 16'hA5C3);
    run(0, 2'd1, 2'b11, 5'h05, 5'h03, 16'h0, 1'b1, 16'h1234);
    // Preamble suppressed: C45 address frame, first MDC bit must be ST=00
    run(1, 2'd1, 2'b00, 5'h02, 5'h01, 16'h0005, 1'b0, 16'h0);
    chk("first_bits_st", 64'(mon_o[1][31:30]), 64'd0);

    // randomized frames on both instances
    for (int i = 0; i < 8; i++) begin
      g  = $urandom_range(0, 1);
      c  = 2'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      pa = 5'($urandom);
      da = 5'($urandom);
      wd = 16'($urandom);
      run(g, c, op, pa, da, wd, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    // start mid-frame and in DONE ignored, start one cycle after DONE accepted
    phy_mode[0] = 1'b0;
    phy_data[0] = 16'h5AA5;
    start_frame(0, 2'd0, 2'b01, 5'h0A, 5'h11, 16'hBEEF);
    repeat (100) @(posedge clk);
    #1;
    set_req(0, 2'd0, 2'b01, 5'h1F, 5'h1F, 16'hFFFF);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (!done_w[0] && n < 4000) begin @(posedge clk); #1; n++; end
    chk("done_reached", 64'(done_w[0]), 64'd1);
    check_bits(0, 2'd0, 2'b01, 5'h0A, 5'h11, 16'hBEEF);
    set_req(0, 2'd0, 2'b01, 5'h1F, 5'h00, 16'h0F0F);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    set_req(0, 2'd1, 2'b11, 5'h07, 5'h1E, 16'h0000);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0);
    check_frame(0, 2'd1, 2'b11, 5'h07, 5'h1E, 16'h0000);

    // reset during a DATA bit aborts the frame
    start_frame(0, 2'd0, 2'b01, 5'h03, 5'h04, 16'hC3C3);
    n = 0;
    while (mon_n[0] < 52 && n < 4000) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_mdio_t", 64'(t_w[0]), 64'd1);
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_mdc", 64'(mdc_w[0]), 64'd0);
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(mon_done[0]), 64'd0);
    chk("abort_rd_data", 64'(rd_data0), 64'(exp_rd[0]));
    run(0, 2'd1, 2'b10, 5'h09, 5'h01, 16'h0, 1'b0, 16'h8001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
